// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Optional build macro: CONTROL_ADDI_EN adds the ADDI sequence (ADDIEXEC/ADDIWB).
package control_pkg;

    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;
    localparam int ALU_W   = 3;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        BRANCH,
        JUMP,
        TRAP
`ifdef CONTROL_ADDI_EN
        , ADDIEXEC,
        ADDIWB
`endif
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`ifdef CONTROL_ADDI_EN
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    // alu_op: how the decoder should pick the ALU operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction-register / memory / datapath-control bundle of the control unit.
// master = control unit, slave = datapath and memory side.
interface multicycle_control_unit_if #(
    parameter int ALU_CNTRL_WIDTH_P = 3,
    parameter int FUNCT_WIDTH_P     = 6,
    parameter int OP_WIDTH_P        = 6
);
    logic [OP_WIDTH_P-1:0]        i_opcode;
    logic [FUNCT_WIDTH_P-1:0]     i_function;
    logic                         i_mem_ready;
    logic                         i_alu_zero;
    logic                         o_mem_rd_en;
    logic                         o_mem_wr_en;
    logic                         o_iord_sel;
    logic                         o_ir_wr_en;
    logic                         o_pc_en;
    logic [1:0]                   o_pc_src_sel;
    logic                         o_alu_src_a_sel;
    logic [1:0]                   o_alu_src_b_sel;
    logic [ALU_CNTRL_WIDTH_P-1:0] o_alu_cntrl;
    logic                         o_reg_wr_en;
    logic                         o_reg_wr_addr_sel;
    logic                         o_reg_wr_data_sel;
    logic                         o_instr_done;
    logic                         o_illegal_op;

    modport master (
        input  i_opcode, i_function, i_mem_ready, i_alu_zero,
        output o_mem_rd_en, o_mem_wr_en, o_iord_sel, o_ir_wr_en, o_pc_en,
               o_pc_src_sel, o_alu_src_a_sel, o_alu_src_b_sel, o_alu_cntrl,
               o_reg_wr_en, o_reg_wr_addr_sel, o_reg_wr_data_sel,
               o_instr_done, o_illegal_op
    );

    modport slave (
        output i_opcode, i_function, i_mem_ready, i_alu_zero,
        input  o_mem_rd_en, o_mem_wr_en, o_iord_sel, o_ir_wr_en, o_pc_en,
               o_pc_src_sel, o_alu_src_a_sel, o_alu_src_b_sel, o_alu_cntrl,
               o_reg_wr_en, o_reg_wr_addr_sel, o_reg_wr_data_sel,
               o_instr_done, o_illegal_op
    );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder: {alu_op, funct} -> ALU control code, flags unsupported R-type funct.
module alu_decoder
    import control_pkg::*;
(
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [ALU_W-1:0]   alu_cntrl,
    output logic               funct_illegal
);

    // Unsupported funct yields the AND code (000) with the illegal flag raised.
    always_comb begin
        alu_cntrl     = ALU_AND;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_cntrl = ALU_ADD;
            ALUOP_SUB: alu_cntrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_cntrl = ALU_ADD;
                    FN_SUB:  alu_cntrl = ALU_SUB;
                    FN_AND:  alu_cntrl = ALU_AND;
                    FN_OR:   alu_cntrl = ALU_OR;
                    FN_SLT:  alu_cntrl = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_cntrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback; only ir_wr_en, pc write and instr_done are gated by mem_ready.
// Optional build macro: CONTROL_ADDI_EN enables the ADDI instruction.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4, wait for ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEMADR   | effective address for LW/SW
// MEMRD    | data read, wait for ready
// MEMWB    | load data -> rt
// MEMWR    | data write, wait for ready
// EXECUTE  | R-type ALU operation
// ALUWB    | ALUOut -> rd
// BRANCH   | compare, PC <- ALUOut when equal
// JUMP     | PC <- jump target
// TRAP     | illegal instruction pulse
// ADDIEXEC | rs + sign-ext imm (CONTROL_ADDI_EN)
// ADDIWB   | ALUOut -> rt (CONTROL_ADDI_EN)
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int ALU_CNTRL_WIDTH_P = 3,
    parameter int FUNCT_WIDTH_P     = 6,
    parameter int OP_WIDTH_P        = 6
) (
    input logic                      i_clk,
    input logic                      i_rst_n,
    multicycle_control_unit_if.master bus
);

    state_t state_q, state_d;

    logic [OP_WIDTH_P-1:0]        opcode;
    logic [FUNCT_WIDTH_P-1:0]     funct;
    logic [ALU_CNTRL_WIDTH_P-1:0] alu_cntrl;
    logic                         funct_illegal;
    logic [1:0]                   alu_op;
    logic                         alu_used;

    logic       mem_rd_en, mem_wr_en, iord_sel, ir_wr_en, pc_wr, branch;
    logic [1:0] pc_src_sel, src_b_sel;
    logic       src_a_sel, reg_wr_en, addr_sel, data_sel, instr_done, illegal_op;

    assign opcode = bus.i_opcode;
    assign funct  = bus.i_function;

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_cntrl     (alu_cntrl),
        .funct_illegal (funct_illegal)
    );

    // State register; reset abandons any partial instruction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    // ALU operation selection, kept apart from the FSM so funct_illegal never loops back.
    always_comb begin
        alu_used = 1'b0;
        alu_op   = ALUOP_ADD;
        case (state_q)
            FETCH, DECODE, MEMADR: alu_used = 1'b1;
            EXECUTE: begin alu_used = 1'b1; alu_op = ALUOP_FUNCT; end
            BRANCH:  begin alu_used = 1'b1; alu_op = ALUOP_SUB;   end
`ifdef CONTROL_ADDI_EN
            ADDIEXEC: alu_used = 1'b1;
`endif
            default: ;
        endcase
    end

    // Next state and Moore-decoded controls.
    always_comb begin
        state_d    = state_q;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        iord_sel   = 1'b0;
        ir_wr_en   = 1'b0;
        pc_wr      = 1'b0;
        branch     = 1'b0;
        pc_src_sel = PCSRC_ALU;
        src_a_sel  = 1'b0;
        src_b_sel  = SRCB_REG;
        reg_wr_en  = 1'b0;
        addr_sel   = 1'b0;
        data_sel   = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                mem_rd_en = 1'b1;
                src_b_sel = SRCB_FOUR;
                if (bus.i_mem_ready) begin
                    ir_wr_en = 1'b1;
                    pc_wr    = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                src_b_sel = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef CONTROL_ADDI_EN
                    OP_ADDI:      state_d = ADDIEXEC;
`endif
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR: begin
                src_a_sel = 1'b1;
                src_b_sel = SRCB_IMM;
                state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_rd_en = 1'b1;
                iord_sel  = 1'b1;
                if (bus.i_mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                reg_wr_en  = 1'b1;
                data_sel   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_wr_en = 1'b1;
                iord_sel  = 1'b1;
                if (bus.i_mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end
            EXECUTE: begin
                src_a_sel = 1'b1;
                state_d   = funct_illegal ? TRAP : ALUWB;
            end
            ALUWB: begin
                reg_wr_en  = 1'b1;
                addr_sel   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                src_a_sel  = 1'b1;
                branch     = 1'b1;
                pc_src_sel = PCSRC_ALUOUT;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pc_src_sel = PCSRC_JUMP;
                pc_wr      = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
                illegal_op = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`ifdef CONTROL_ADDI_EN
            ADDIEXEC: begin
                src_a_sel = 1'b1;
                src_b_sel = SRCB_IMM;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_wr_en  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    assign bus.o_mem_rd_en       = mem_rd_en;
    assign bus.o_mem_wr_en       = mem_wr_en;
    assign bus.o_iord_sel        = iord_sel;
    assign bus.o_ir_wr_en        = ir_wr_en;
    assign bus.o_pc_en           = pc_wr | (branch & bus.i_alu_zero);
    assign bus.o_pc_src_sel      = pc_src_sel;
    assign bus.o_alu_src_a_sel   = src_a_sel;
    assign bus.o_alu_src_b_sel   = src_b_sel;
    assign bus.o_alu_cntrl       = alu_used ? alu_cntrl : '0;
    assign bus.o_reg_wr_en       = reg_wr_en;
    assign bus.o_reg_wr_addr_sel = addr_sel;
    assign bus.o_reg_wr_data_sel = data_sel;
    assign bus.o_instr_done      = instr_done;
    assign bus.o_illegal_op      = illegal_op;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       ir_wr;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic       reg_wr;
        logic       addr_sel;
        logic       data_sel;
        logic       done;
        logic       illegal;
    } outs_t;

    typedef struct {
        outs_t wait_o;
        outs_t rdy_o;
        bit    is_wait;
    } phase_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         lat;
        int         ill;
        int         regwr;
        int         memwr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    bit   rand_rdy;
    bit   rdy_q[$];
    phase_t ph[$];
    vec_t   tbl[$];

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic outs_t sample();
        outs_t s;
        s.mem_rd   = bus.o_mem_rd_en;
        s.mem_wr   = bus.o_mem_wr_en;
        s.iord     = bus.o_iord_sel;
        s.ir_wr    = bus.o_ir_wr_en;
        s.pc_en    = bus.o_pc_en;
        s.pc_src   = bus.o_pc_src_sel;
        s.src_a    = bus.o_alu_src_a_sel;
        s.src_b    = bus.o_alu_src_b_sel;
        s.alu      = bus.o_alu_cntrl;
        s.reg_wr   = bus.o_reg_wr_en;
        s.addr_sel = bus.o_reg_wr_addr_sel;
        s.data_sel = bus.o_reg_wr_data_sel;
        s.done     = bus.o_instr_done;
        s.illegal  = bus.o_illegal_op;
        return s;
    endfunction

    // {legal, alu code} for an R-type funct field
    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1010;
            6'b100010: return 4'b1110;
            6'b100100: return 4'b1000;
            6'b100101: return 4'b1001;
            6'b101010: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic void push(input outs_t w, input outs_t r, input bit is_w);
        phase_t p;
        p.wait_o = w; p.rdy_o = r; p.is_wait = is_w;
        ph.push_back(p);
    endfunction

    function automatic outs_t trap_o();
        outs_t a;
        a = '0; a.illegal = 1'b1; a.done = 1'b1;
        return a;
    endfunction

    // Reference: list of cycle phases an instruction goes through, with its controls.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic z);
        outs_t a, b;
        logic [3:0] rc;
        ph.delete();
        a = '0; a.mem_rd = 1'b1; a.src_b = 2'b01; a.alu = 3'b010;
        b = a;  b.ir_wr = 1'b1; b.pc_en = 1'b1;
        push(a, b, 1'b1);
        a = '0; a.src_b = 2'b11; a.alu = 3'b010;
        push(a, a, 1'b0);
        case (op)
            6'b100011: begin
                a = '0; a.src_a = 1'b1; a.src_b = 2'b10; a.alu = 3'b010; push(a, a, 1'b0);
                a = '0; a.mem_rd = 1'b1; a.iord = 1'b1; push(a, a, 1'b1);
                a = '0; a.reg_wr = 1'b1; a.data_sel = 1'b1; a.done = 1'b1; push(a, a, 1'b0);
            end
            6'b101011: begin
                a = '0; a.src_a = 1'b1; a.src_b = 2'b10; a.alu = 3'b010; push(a, a, 1'b0);
                a = '0; a.mem_wr = 1'b1; a.iord = 1'b1;
                b = a;  b.done = 1'b1; push(a, b, 1'b1);
            end
            6'b000000: begin
                rc = r_alu(fn);
                a = '0; a.src_a = 1'b1; a.alu = rc[2:0]; push(a, a, 1'b0);
                if (rc[3]) begin
                    a = '0; a.reg_wr = 1'b1; a.addr_sel = 1'b1; a.done = 1'b1; push(a, a, 1'b0);
                end else begin
                    push(trap_o(), trap_o(), 1'b0);
                end
            end
            6'b000100: begin
                a = '0; a.src_a = 1'b1; a.alu = 3'b110; a.pc_src = 2'b01;
                a.pc_en = z; a.done = 1'b1; push(a, a, 1'b0);
            end
            6'b000010: begin
                a = '0; a.pc_src = 2'b10; a.pc_en = 1'b1; a.done = 1'b1; push(a, a, 1'b0);
            end
`ifdef CONTROL_ADDI_EN
            6'b001000: begin
                a = '0; a.src_a = 1'b1; a.src_b = 2'b10; a.alu = 3'b010; push(a, a, 1'b0);
                a = '0; a.reg_wr = 1'b1; a.done = 1'b1; push(a, a, 1'b0);
            end
`endif
            default: push(trap_o(), trap_o(), 1'b0);
        endcase
    endfunction

    function automatic bit next_ready();
        if (rdy_q.size() > 0) return rdy_q.pop_front();
        if (rand_rdy) return ($urandom_range(3) != 0);
        return 1'b1;
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             output int cyc, output int ill, output int rw, output int mw);
        phase_t p;
        outs_t  e, act;
        bit     r;
        int     guard;
        build(op, fn, z);
        cyc = 0; ill = 0; rw = 0; mw = 0;
        while (ph.size() > 0) begin
            p = ph.pop_front();
            guard = 0;
            forever begin
                @(negedge clk);
                r = next_ready();
                bus.i_mem_ready = r;
                bus.i_opcode    = op;
                bus.i_function  = fn;
                bus.i_alu_zero  = z;
                #1;
                act = sample();
                e = (p.is_wait && !r) ? p.wait_o : p.rdy_o;
                chk($sformatf("cycle op=%b fn=%b c=%0d", op, fn, cyc), 32'(act), 32'(e));
                cyc++;
                ill += int'(act.illegal);
                rw  += int'(act.reg_wr);
                mw  += int'(act.mem_wr);
                if (!p.is_wait || r) break;
                guard++;
                if (guard > 40) begin
                    n_total++;
                    $display("FAIL wait_bound: got %0d wait cycles expected at most 40", guard);
                    break;
                end
            end
        end
    endtask

    initial begin
        outs_t fw, act;
        int cyc, ill, rw, mw;
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        logic [5:0] op, fn;

        n_pass = 0; n_total = 0; rand_rdy = 1'b0;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        tbl.push_back('{"r_add", 6'b000000, 6'b100000, 1'b0, 4, 0, 1, 0});
        tbl.push_back('{"r_sub", 6'b000000, 6'b100010, 1'b0, 4, 0, 1, 0});
        tbl.push_back('{"r_and", 6'b000000, 6'b100100, 1'b0, 4, 0, 1, 0});
        tbl.push_back('{"r_or",  6'b000000, 6'b100101, 1'b0, 4, 0, 1, 0});
        tbl.push_back('{"r_slt", 6'b000000, 6'b101010, 1'b0, 4, 0, 1, 0});
        tbl.push_back('{"lw",    6'b100011, 6'b000000, 1'b0, 5, 0, 1, 0});
        tbl.push_back('{"sw",    6'b101011, 6'b000000, 1'b0, 4, 0, 0, 1});
        tbl.push_back('{"beq_t", 6'b000100, 6'b000000, 1'b1, 3, 0, 0, 0});
        tbl.push_back('{"beq_n", 6'b000100, 6'b000000, 1'b0, 3, 0, 0, 0});
        tbl.push_back('{"jump",  6'b000010, 6'b000000, 1'b0, 3, 0, 0, 0});
        tbl.push_back('{"ill_op",6'b111111, 6'b000000, 1'b0, 3, 1, 0, 0});
        tbl.push_back('{"ill_fn",6'b000000, 6'b000111, 1'b0, 4, 1, 0, 0});
`ifdef CONTROL_ADDI_EN
        tbl.push_back('{"addi",  6'b001000, 6'b000000, 1'b0, 4, 0, 1, 0});
`else
        tbl.push_back('{"addi",  6'b001000, 6'b000000, 1'b0, 3, 1, 0, 0});
`endif

        fw = '0; fw.mem_rd = 1'b1; fw.src_b = 2'b01; fw.alu = 3'b010;

        rst_n = 1'b0;
        bus.i_mem_ready = 1'b0;
        bus.i_opcode    = '0;
        bus.i_function  = '0;
        bus.i_alu_zero  = 1'b0;
        #1;
        chk("reset_outputs", 32'(sample()), 32'(fw));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table, ready always high
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, cyc, ill, rw, mw);
            chk({tbl[i].name, "_latency"}, 32'(cyc), 32'(tbl[i].lat));
            chk({tbl[i].name, "_illegal"}, 32'(ill), 32'(tbl[i].ill));
            chk({tbl[i].name, "_regwr"},   32'(rw),  32'(tbl[i].regwr));
            chk({tbl[i].name, "_memwr"},   32'(mw),  32'(tbl[i].memwr));
        end

        // LW with two not-ready cycles in the data read
        rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        run_instr(6'b100011, 6'b000000, 1'b0, cyc, ill, rw, mw);
        chk("lw_wait_latency", 32'(cyc), 32'd7);
        chk("lw_wait_regwr", 32'(rw), 32'd1);

        // reset asserted in the middle of a store
        bus.i_opcode = 6'b101011; bus.i_function = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.i_mem_ready = (c < 3);
        end
        #1;
        chk("memwr_before_reset", 32'(bus.o_mem_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("memwr_async_drop", 32'(bus.o_mem_wr_en), 32'd0);
        chk("reset_to_fetch", 32'(sample()), 32'(fw));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        act = sample();
        chk("fetch_after_reset", 32'(act), 32'(fw));

        // randomized instructions with random ready stalls
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(6)];
            if (op == 6'b111111) op = 6'($urandom_range(63));
            fn = ($urandom_range(1) == 1) ? fns[$urandom_range(4)] : 6'($urandom_range(63));
            run_instr(op, fn, 1'($urandom_range(1)), cyc, ill, rw, mw);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
